// File: rtl/mem_ctl_pkg.sv
// Shared types and lane-layout constants for the parity-protected memory controller.
// Each memory word holds two 9-bit lanes of {parity, byte}.
package mem_ctl_pkg;

  localparam int unsigned LANE_W    = 9;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned WADDR_W   = 17;
  localparam int unsigned MEM_W     = 2 * LANE_W;

  // Lane positions inside the 18-bit memory word
  localparam int unsigned HI_LANE_LSB = 9;
  localparam int unsigned LO_LANE_LSB = 0;
  localparam int unsigned HI_PAR_BIT  = 17;
  localparam int unsigned LO_PAR_BIT  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD1   = 3'd2,
    RD2   = 3'd3,
    RDCAP = 3'd4
  } state_e;

  typedef struct packed {
    logic              par;
    logic [BYTE_W-1:0] data;
  } lane_t;

endpackage

// File: rtl/mem_ctl_if.sv
// Request/response and memory-port bundle for mem_ctl.
// slave = controller view, master = requester/memory (testbench) view.
interface mem_ctl_if
  import mem_ctl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic               req_byte;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic               force_perr;
  logic               rsp_valid;
  logic [DATA_W-1:0]  rsp_rdata;
  logic [1:0]         rsp_perr;
  logic [CNT_W-1:0]   perr_count;
  logic               m_ena;
  logic [1:0]         m_wea;
  logic [WADDR_W-1:0] m_addra;
  logic [MEM_W-1:0]   m_dina;
  logic [MEM_W-1:0]   m_douta;

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata, force_perr, m_douta,
    output req_ready, rsp_valid, rsp_rdata, rsp_perr, perr_count,
           m_ena, m_wea, m_addra, m_dina
  );

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata, force_perr, m_douta,
    input  req_ready, rsp_valid, rsp_rdata, rsp_perr, perr_count,
           m_ena, m_wea, m_addra, m_dina
  );

endinterface

// File: rtl/mem_par_lane.sv
// Parity generator and checker for one {parity, byte} lane.
// Generation may be deliberately inverted for diagnostic error injection.
module mem_par_lane
  import mem_ctl_pkg::*;
#(
  parameter int unsigned ODD_PAR = 1
) (
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_inv,
  input  lane_t             i_lane,
  output logic              o_par_c,
  output logic              o_err_c
);

  logic w_odd;

  assign w_odd   = 1'(ODD_PAR);
  assign o_par_c = (^i_data) ^ w_odd ^ i_inv;
  assign o_err_c = i_lane.par ^ (^i_lane.data) ^ w_odd;

endmodule

// File: rtl/mem_ctl.sv
// Single-port parity-protected memory controller: one request at a time,
// fixed 1-cycle write acknowledge and 3-cycle read response.
module mem_ctl
  import mem_ctl_pkg::*;
#(
  parameter int unsigned ODD_PAR = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic     CLOCK,
  input  logic     RESET_N,
  mem_ctl_if.slave bus
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_accept;

  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic [1:0]         r_rsp_perr;
  logic [CNT_W-1:0]   r_perr_count;
  logic               r_m_ena;
  logic [1:0]         r_m_wea;
  logic [WADDR_W-1:0] r_m_addra;
  logic [MEM_W-1:0]   r_m_dina;

  logic [BYTE_W-1:0]  w_wr_hi;
  logic [BYTE_W-1:0]  w_wr_lo;
  logic [1:0]         w_wea_nxt;
  logic               w_par_hi;
  logic               w_par_lo;
  logic               w_err_hi;
  logic               w_err_lo;

  // Byte writes replicate the byte onto both lanes; m_wea selects the lane.
  assign w_wr_hi   = bus.req_byte ? bus.req_wdata[BYTE_W-1:0] : bus.req_wdata[DATA_W-1:BYTE_W];
  assign w_wr_lo   = bus.req_wdata[BYTE_W-1:0];
  assign w_wea_nxt = !bus.req_byte ? 2'b11 : (bus.req_addr[0] ? 2'b10 : 2'b01);

  mem_par_lane #(.ODD_PAR(ODD_PAR)) u_lane_hi (
    .i_data  (w_wr_hi),
    .i_inv   (bus.force_perr),
    .i_lane  (lane_t'(bus.m_douta[HI_PAR_BIT:HI_LANE_LSB])),
    .o_par_c (w_par_hi),
    .o_err_c (w_err_hi)
  );

  mem_par_lane #(.ODD_PAR(ODD_PAR)) u_lane_lo (
    .i_data  (w_wr_lo),
    .i_inv   (bus.force_perr),
    .i_lane  (lane_t'(bus.m_douta[LO_PAR_BIT:LO_LANE_LSB])),
    .o_par_c (w_par_lo),
    .o_err_c (w_err_lo)
  );

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = bus.req_valid & r_req_ready;
        if (w_accept) begin
          w_state_nxt = bus.req_write ? WR : RD1;
        end
      end
      WR:      w_state_nxt = IDLE;
      RD1:     w_state_nxt = RD2;
      RD2:     w_state_nxt = RDCAP;
      RDCAP:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; ready is re-armed only on the edge entering IDLE.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_perr   <= '0;
      r_perr_count <= '0;
      r_m_ena      <= 1'b0;
      r_m_wea      <= '0;
      r_m_addra    <= '0;
      r_m_dina     <= '0;
    end else begin
      r_m_ena     <= 1'b1;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= 1'b0;

      if (w_accept) begin
        r_m_addra <= bus.req_addr[ADDR_W-1:1];
        if (bus.req_write) begin
          r_m_wea  <= w_wea_nxt;
          r_m_dina <= {w_par_hi, w_wr_hi, w_par_lo, w_wr_lo};
        end
      end

      case (r_state)
        WR: begin
          r_m_wea     <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= '0;
          r_rsp_perr  <= '0;
        end
        RDCAP: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= {bus.m_douta[HI_PAR_BIT-1:HI_LANE_LSB],
                          bus.m_douta[LO_PAR_BIT-1:LO_LANE_LSB]};
          r_rsp_perr  <= {w_err_hi, w_err_lo};
          if ((w_err_hi | w_err_lo) && (r_perr_count != {CNT_W{1'b1}})) begin
            r_perr_count <= r_perr_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rsp_perr   = r_rsp_perr;
  assign bus.perr_count = r_perr_count;
  assign bus.m_ena      = r_m_ena;
  assign bus.m_wea      = r_m_wea;
  assign bus.m_addra    = r_m_addra;
  assign bus.m_dina     = r_m_dina;

endmodule

// File: tb/tb_mem_ctl.sv
// Directed testbench for mem_ctl with a 2-cycle-latency lane-writable memory model.
module tb_mem_ctl;
  import mem_ctl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mem_ctl_if #(.CNT_W(2)) bus ();

  mem_ctl #(.ODD_PAR(1), .CNT_W(2)) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // memarray: 128K x 18 memory, per-lane write enables, 2-cycle registered read
  logic [17:0] memarray [0:131071];
  logic [17:0] mem_pipe;

  always @(posedge clk) begin
    if (bus.m_ena) begin
      if (bus.m_wea[1]) memarray[bus.m_addra][17:9] <= bus.m_dina[17:9];
      if (bus.m_wea[0]) memarray[bus.m_addra][8:0]  <= bus.m_dina[8:0];
      mem_pipe    <= memarray[bus.m_addra];
      bus.m_douta <= mem_pipe;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Issues one request, waits (bounded) for acceptance and the response strobe.
  task automatic do_req(input logic wr, input logic byt, input logic [17:0] addr,
                        input logic [15:0] wd, input logic fp,
                        output logic acc, output logic [1:0] wea_a, output logic [17:0] dina_a,
                        output logic [16:0] addra_a, output logic [1:0] wea_r, output int lat,
                        output logic [15:0] rd, output logic [1:0] pe, output logic [1:0] pc,
                        output logic dbl);
    bus.req_write  = wr;
    bus.req_byte   = byt;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.force_perr = fp;
    bus.req_valid  = 1'b1;
    acc = 1'b0; lat = -1; rd = 'x; pe = 'x; pc = 'x; wea_r = 'x; dbl = 1'b0;
    wea_a = 'x; dina_a = 'x; addra_a = 'x;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) acc = 1'b1;
      @(posedge clk); #1;
      if (acc) break;
    end
    bus.req_valid  = 1'b0;
    bus.force_perr = 1'b0;
    if (acc) begin
      wea_a = bus.m_wea; dina_a = bus.m_dina; addra_a = bus.m_addra;
      for (int i = 1; i <= 8; i++) begin
        @(posedge clk); #1;
        if (bus.rsp_valid) begin
          lat = i; rd = bus.rsp_rdata; pe = bus.rsp_perr; pc = bus.perr_count; wea_r = bus.m_wea;
          break;
        end
      end
      @(posedge clk); #1;
      dbl = bus.rsp_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.force_perr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.m_ena, bus.m_wea, bus.rsp_valid, bus.rsp_perr} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {bus.req_ready, bus.m_ena, bus.m_wea, bus.rsp_valid, bus.rsp_perr});
    end
    checks++;
    if ({bus.m_addra, bus.m_dina, bus.rsp_rdata, bus.perr_count} !== 53'b0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {bus.m_addra, bus.m_dina, bus.rsp_rdata, bus.perr_count});
    end
    checks++;
    if (dut.r_state !== IDLE) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, IDLE);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.m_ena, bus.req_ready} !== 2'b11) begin
      failures++; $display("FAIL release_ena_ready got=%b exp=11", {bus.m_ena, bus.req_ready});
    end
  endtask

  task automatic test_word_write_read();
    logic acc, dbl; logic [1:0] wea_a, wea_r, pe, pc; logic [17:0] dina_a; logic [16:0] addra_a;
    int lat; logic [15:0] rd;
    do_req(1'b1, 1'b0, 18'o001000, 16'o123456, 1'b0, acc, wea_a, dina_a, addra_a, wea_r, lat, rd, pe, pc, dbl);
    checks++;
    if (acc !== 1'b1 || wea_a !== 2'b11) begin
      failures++; $display("FAIL wr_word_wea acc=%b got=%b exp=11", acc, wea_a);
    end
    checks++;
    if (dina_a !== 18'h14F2E || addra_a !== 17'd256) begin
      failures++; $display("FAIL wr_word_bus dina=%h exp=14f2e addra=%0d exp=256", dina_a, addra_a);
    end
    checks++;
    if (lat !== 1 || wea_r !== 2'b00 || rd !== 16'h0 || pe !== 2'b00 || dbl !== 1'b0) begin
      failures++;
      $display("FAIL wr_word_ack lat=%0d exp=1 wea=%b exp=00 rd=%h pe=%b dbl=%b", lat, wea_r, rd, pe, dbl);
    end
    do_req(1'b0, 1'b0, 18'o001000, 16'h0, 1'b0, acc, wea_a, dina_a, addra_a, wea_r, lat, rd, pe, pc, dbl);
    checks++;
    if (acc !== 1'b1 || wea_a !== 2'b00 || lat !== 3) begin
      failures++; $display("FAIL rd_word_lat acc=%b wea=%b lat=%0d exp=3", acc, wea_a, lat);
    end
    checks++;
    if (rd !== 16'o123456 || pe !== 2'b00 || dbl !== 1'b0) begin
      failures++; $display("FAIL rd_word_data got=%o exp=123456 pe=%b dbl=%b", rd, pe, dbl);
    end
  endtask

  task automatic test_byte_write();
    logic acc, dbl; logic [1:0] wea_a, wea_r, pe, pc; logic [17:0] dina_a; logic [16:0] addra_a;
    int lat; logic [15:0] rd;
    do_req(1'b1, 1'b1, 18'o001001, 16'o000377, 1'b0, acc, wea_a, dina_a, addra_a, wea_r, lat, rd, pe, pc, dbl);
    checks++;
    if (wea_a !== 2'b10 || dina_a !== 18'h3FFFF || lat !== 1) begin
      failures++; $display("FAIL wr_byte wea=%b exp=10 dina=%h exp=3ffff lat=%0d", wea_a, dina_a, lat);
    end
    do_req(1'b0, 1'b0, 18'o001000, 16'h0, 1'b0, acc, wea_a, dina_a, addra_a, wea_r, lat, rd, pe, pc, dbl);
    checks++;
    if (rd !== 16'o177456 || pe !== 2'b00 || lat !== 3) begin
      failures++; $display("FAIL rd_byte got=%o exp=177456 pe=%b lat=%0d", rd, pe, lat);
    end
    do_req(1'b1, 1'b1, 18'o001000, 16'h0011, 1'b0, acc, wea_a, dina_a, addra_a, wea_r, lat, rd, pe, pc, dbl);
    checks++;
    if (wea_a !== 2'b01) begin
      failures++; $display("FAIL wr_byte_lo wea=%b exp=01", wea_a);
    end
    do_req(1'b0, 1'b0, 18'o001001, 16'h0, 1'b0, acc, wea_a, dina_a, addra_a, wea_r, lat, rd, pe, pc, dbl);
    checks++;
    if (rd !== 16'hFF11 || pe !== 2'b00) begin
      failures++; $display("FAIL rd_byte_lo got=%h exp=ff11 pe=%b", rd, pe);
    end
  endtask

  task automatic test_force_perr();
    logic acc, dbl; logic [1:0] wea_a, wea_r, pe, pc; logic [17:0] dina_a; logic [16:0] addra_a;
    int lat; logic [15:0] rd;
    checks++;
    if (bus.perr_count !== 2'd0) begin
      failures++; $display("FAIL perr_count_init got=%0d exp=0", bus.perr_count);
    end
    do_req(1'b1, 1'b0, 18'o002000, 16'h1234, 1'b1, acc, wea_a, dina_a, addra_a, wea_r, lat, rd, pe, pc, dbl);
    checks++;
    if (dina_a !== 18'h02534) begin
      failures++; $display("FAIL wr_force_dina got=%h exp=02534", dina_a);
    end
    do_req(1'b0, 1'b0, 18'o002000, 16'h0, 1'b0, acc, wea_a, dina_a, addra_a, wea_r, lat, rd, pe, pc, dbl);
    checks++;
    if (pe !== 2'b11 || rd !== 16'h1234 || pc !== 2'd1) begin
      failures++; $display("FAIL rd_force pe=%b exp=11 rd=%h exp=1234 count=%0d exp=1", pe, rd, pc);
    end
  endtask

  task automatic test_perr_saturate();
    logic acc, dbl; logic [1:0] wea_a, wea_r, pe, pc; logic [17:0] dina_a; logic [16:0] addra_a;
    int lat; logic [15:0] rd;
    logic [1:0] exp_cnt [3];
    exp_cnt[0] = 2'd2; exp_cnt[1] = 2'd3; exp_cnt[2] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      do_req(1'b0, 1'b0, 18'o002000, 16'h0, 1'b0, acc, wea_a, dina_a, addra_a, wea_r, lat, rd, pe, pc, dbl);
      checks++;
      if (pc !== exp_cnt[k] || pe !== 2'b11) begin
        failures++; $display("FAIL perr_sat_%0d count=%0d exp=%0d pe=%b", k, pc, exp_cnt[k], pe);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int rsp_seen = 0;
    bus.req_write = 1'b0; bus.req_byte = 1'b0; bus.req_addr = 18'o001000; bus.req_valid = 1'b1;
    for (int i = 0; i < 10 && !bus.req_ready; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dut.r_state !== RD2) begin
      failures++; $display("FAIL mid_rd_state got=%0d exp=%0d", dut.r_state, RD2);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dut.r_state !== IDLE || bus.m_ena !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_rd_reset state=%0d ena=%b rsp=%b rdy=%b exp=0,0,0,0",
               dut.r_state, bus.m_ena, bus.rsp_valid, bus.req_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.m_ena !== 1'b1) begin
      failures++; $display("FAIL mid_rd_release ena=%b exp=1", bus.m_ena);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid) rsp_seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (rsp_seen !== 0) begin
      failures++; $display("FAIL mid_rd_no_rsp got=%0d exp=0", rsp_seen);
    end
  endtask

  task automatic test_back_to_back();
    int acc_edge [2];
    int n_acc = 0;
    int n_rsp = 0;
    logic a;
    acc_edge[0] = -1; acc_edge[1] = -1;
    bus.req_write = 1'b1; bus.req_byte = 1'b0; bus.req_addr = 18'o003000;
    bus.req_wdata = 16'h5A5A; bus.force_perr = 1'b0; bus.req_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      a = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      if (a) begin
        if (n_acc < 2) acc_edge[n_acc] = cyc;
        n_acc++;
        if (n_acc == 2) bus.req_valid = 1'b0;
      end
      if (bus.rsp_valid) n_rsp++;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (n_acc !== 2 || (acc_edge[1] - acc_edge[0]) !== 2) begin
      failures++; $display("FAIL b2b_accept n=%0d exp=2 gap=%0d exp=2", n_acc, acc_edge[1] - acc_edge[0]);
    end
    checks++;
    if (n_rsp !== 2) begin
      failures++; $display("FAIL b2b_rsp got=%0d exp=2", n_rsp);
    end
  endtask

  initial begin
    test_reset();
    test_word_write_read();
    test_byte_write();
    test_force_perr();
    test_perr_saturate();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
